// File: rtl/alu_arbiter.sv
// Two-requester ALU arbiter: grant, execute, respond, count.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins).
module alu_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [7:0]       req0_op1,
  input  logic [7:0]       req0_op2,
  input  logic [7:0]       req1_op1,
  input  logic [7:0]       req1_op2,
  input  logic [1:0]       req0_op,
  input  logic [1:0]       req1_op,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [7:0]       rsp_data,
  output logic             rsp_zero,
  output logic             busy,
  output logic [CNT_W-1:0] ops_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_grant;
  logic [7:0]       r_op1;
  logic [7:0]       r_op2;
  logic [1:0]       r_op;
  logic [7:0]       r_res;
  logic             r_zero;
  logic [CNT_W-1:0] r_cnt;
  logic             w_win;
  logic             w_acc;
  logic             w_hs;
  logic [7:0]       w_alu;

`ifdef ALU_ARB_FIXED_PRIO_EN
  // Requester 1 wins only when requester 0 is idle
  always_comb begin
    w_win = ~req_valid[0];
  end
`else
  logic r_last;

  // Contention goes to the requester not served last
  always_comb begin
    w_win = ~req_valid[0];
    if (&req_valid) w_win = ~r_last;
  end

  // Remember the last grant; reset favours requester 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_last <= 1'b1;
    else if (w_acc) r_last <= w_win;
  end
`endif

  assign w_acc = (r_state == S_IDLE) && (|req_valid);
  assign w_hs  = (r_state == S_RESP) && rsp_ready[r_grant];

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_acc) w_next = S_EXEC;
      S_EXEC: w_next = S_RESP;
      S_RESP: if (w_hs) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // ALU on the latched operands
  always_comb begin
    w_alu = 8'h00;
    unique case (r_op)
      2'b00: w_alu = r_op1 & r_op2;
      2'b01: w_alu = r_op1 | r_op2;
      2'b10: w_alu = r_op1 ^ r_op2;
      2'b11: w_alu = ~r_op1;
      default: w_alu = 8'h00;
    endcase
  end

  // Operand capture, result register and op counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant <= 1'b0;
      r_op1   <= 8'h00;
      r_op2   <= 8'h00;
      r_op    <= 2'b00;
      r_res   <= 8'h00;
      r_zero  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      if (w_acc) begin
        r_grant <= w_win;
        r_op1   <= w_win ? req1_op1 : req0_op1;
        r_op2   <= w_win ? req1_op2 : req0_op2;
        r_op    <= w_win ? req1_op : req0_op;
      end
      if (r_state == S_EXEC) begin
        r_res  <= w_alu;
        r_zero <= (w_alu == 8'h00);
      end
      if (w_hs) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign req_ready = (rst_n && w_acc) ?
                     (w_win ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_valid = (r_state == S_RESP) ?
                     (r_grant ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_data  = r_res;
  assign rsp_zero  = r_zero;
  assign busy      = (r_state != S_IDLE);
  assign ops_done  = r_cnt;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter (CNT_W=4 build).
// Honours ALU_ARB_FIXED_PRIO_EN for the contention grants.
module tb_alu_arbiter;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    req_valid = 2'b00;
  logic [1:0]    req_ready;
  logic [7:0]    req0_op1 = 8'h00;
  logic [7:0]    req0_op2 = 8'h00;
  logic [7:0]    req1_op1 = 8'h00;
  logic [7:0]    req1_op2 = 8'h00;
  logic [1:0]    req0_op = 2'b00;
  logic [1:0]    req1_op = 2'b00;
  logic [1:0]    rsp_valid;
  logic [1:0]    rsp_ready = 2'b00;
  logic [7:0]    rsp_data;
  logic          rsp_zero;
  logic          busy;
  logic [CW-1:0] ops_done;

  int            tests = 0;
  int            fails = 0;
  logic [CW-1:0] exp_cnt = '0;
  logic          exp_g;

  alu_arbiter #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_op1(req0_op1), .req0_op2(req0_op2),
    .req1_op1(req1_op1), .req1_op2(req1_op2),
    .req0_op(req0_op), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero),
    .busy(busy), .ops_done(ops_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_ops();
    req0_op1 = 8'h0F; req0_op2 = 8'hF0; req0_op = 2'b01;
    req1_op1 = 8'h12; req1_op2 = 8'h34; req1_op = 2'b00;
  endtask

  // accept, latency, response, handshake, count
  task automatic run_one(input logic [1:0] vld,
                         input logic g,
                         input logic [7:0] d,
                         input logic z);
    @(negedge clk);
    req_valid = vld;
    #1 chk("accept_ready", req_ready, g ? 2'b10 : 2'b01);
    chk("idle_busy", busy, 1'b0);
    @(negedge clk);
    req_valid = 2'b00;
    req0_op1 = 8'h5A; req0_op2 = 8'hC3; req0_op = 2'b10;
    req1_op1 = 8'h5A; req1_op2 = 8'hC3; req1_op = 2'b10;
    #1 chk("exec_rsp_valid", rsp_valid, 2'b00);
    chk("exec_busy", busy, 1'b1);
    @(negedge clk);
    rsp_ready = 2'b11;
    req_valid = vld;
    #1 chk("resp_valid", rsp_valid, g ? 2'b10 : 2'b01);
    chk("resp_data", rsp_data, d);
    chk("resp_zero", rsp_zero, z);
    chk("hs_no_accept", req_ready, 2'b00);
    @(negedge clk);
    rsp_ready = 2'b00;
    req_valid = 2'b00;
    exp_cnt = exp_cnt + 1'b1;
    #1 chk("post_rsp_valid", rsp_valid, 2'b00);
    chk("post_busy", busy, 1'b0);
    chk("ops_done", ops_done, exp_cnt);
  endtask

  initial begin
    #1;
    chk("rst_ready", req_ready, 2'b00);
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_data", rsp_data, 8'h00);
    chk("rst_zero", rsp_zero, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ops", ops_done, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // AND from requester 0
    req0_op1 = 8'hF0; req0_op2 = 8'h3C; req0_op = 2'b00;
    run_one(2'b01, 1'b0, 8'h30, 1'b0);

    // XOR and NOT from requester 1, both zero
    req1_op1 = 8'hA5; req1_op2 = 8'hA5; req1_op = 2'b10;
    run_one(2'b10, 1'b1, 8'h00, 1'b1);
    req1_op1 = 8'hFF; req1_op2 = 8'h00; req1_op = 2'b11;
    run_one(2'b10, 1'b1, 8'h00, 1'b1);

    // contention: alternate (or fixed to 0)
    for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      exp_g = 1'b0;
`else
      exp_g = i[0];
`endif
      set_ops();
      run_one(2'b11, exp_g,
              exp_g ? 8'h10 : 8'hFF, 1'b0);
    end

    // stall in RESP for 5 cycles
    @(negedge clk);
    req0_op1 = 8'hF0; req0_op2 = 8'h3C; req0_op = 2'b00;
    req_valid = 2'b01;
    #1 chk("stall_accept", req_ready, 2'b01);
    @(negedge clk);
    req_valid = 2'b11;
    req0_op1 = 8'h00;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      #1 chk("stall_valid", rsp_valid, 2'b01);
      chk("stall_data", rsp_data, 8'h30);
      chk("stall_zero", rsp_zero, 1'b0);
      chk("stall_ready", req_ready, 2'b00);
      chk("stall_busy", busy, 1'b1);
      @(negedge clk);
    end
    rsp_ready = 2'b10;
    #1 chk("wrong_bit_ignored", rsp_valid, 2'b01);
    @(negedge clk);
    req_valid = 2'b00;
    rsp_ready = 2'b01;
    @(negedge clk);
    rsp_ready = 2'b00;
    exp_cnt = exp_cnt + 1'b1;
    #1 chk("stall_ops", ops_done, exp_cnt);
    chk("stall_idle", busy, 1'b0);

    // reset pulse during EXEC
    @(negedge clk);
    req1_op1 = 8'h11; req1_op2 = 8'h22; req1_op = 2'b01;
    req_valid = 2'b10;
    #1 chk("exec_rst_accept", req_ready, 2'b10);
    @(negedge clk);
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    #1 rst_n = 1'b0;
    #1 chk("arst_busy", busy, 1'b0);
    chk("arst_ready", req_ready, 2'b00);
    chk("arst_valid", rsp_valid, 2'b00);
    chk("arst_data", rsp_data, 8'h00);
    chk("arst_ops", ops_done, 0);
    exp_cnt = '0;
    @(negedge clk);
    chk("arst_hold_valid", rsp_valid, 2'b00);
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    rst_n = 1'b1;
    set_ops();
    run_one(2'b11, 1'b0, 8'hFF, 1'b0);

    // walk the counter to all-ones, then wrap
    while (exp_cnt != '1) begin
      set_ops();
      run_one(2'b01, 1'b0, 8'hFF, 1'b0);
    end
    chk("cnt_full", ops_done, 4'hF);
    set_ops();
    run_one(2'b01, 1'b0, 8'hFF, 1'b0);
    chk("cnt_wrap", ops_done, 4'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, the width of the completed-operation counter.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 The block SHALL have port req_valid, input, 2, per-requester operation request (bit i = requester i).
REQ-005 The block SHALL have port req_ready, output, 2, per-requester operation accepted this cycle.
REQ-006 The block SHALL have ports req0_op1, req0_op2, req1_op1, req1_op2, input, 8 each, the operands.
REQ-007 The block SHALL have ports req0_op and req1_op, input, 2 each, the ALU op code (00 AND, 01 OR, 10 XOR, 11 NOT op1).
REQ-008 The block SHALL have port rsp_valid, output, 2, result valid for requester i.
REQ-009 The block SHALL have port rsp_ready, input, 2, requester i consumes the result.
REQ-010 The block SHALL have port rsp_data, output, 8, the shared result bus.
REQ-011 The block SHALL have port rsp_zero, output, 1, result == 8'h00.
REQ-012 The block SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-013 The block SHALL have port ops_done, output, CNT_W, the completed-operation count.

Function
REQ-014 The block SHALL implement FSM states IDLE, EXEC and RESP.
REQ-015 In IDLE with any req_valid high, the block SHALL grant exactly one requester, assert its req_ready combinationally that cycle, latch its op1/op2/op and the grant index, and enter EXEC.
REQ-016 The grant SHALL be round-robin: on contention the requester not granted most recently wins; an uncontended request SHALL be granted regardless of history.
REQ-017 req_ready SHALL be 0 in EXEC and RESP and for the non-granted requester.
REQ-018 In EXEC the block SHALL compute the latched op with the AND/OR/XOR/NOT semantics of REQ-007, register result and zero flag, and enter RESP.
REQ-019 In RESP the block SHALL hold rsp_valid[grant]=1, rsp_data and rsp_zero stable until rsp_ready[grant]=1, then return to IDLE.
REQ-020 The accept-to-rsp_valid latency SHALL be exactly 2 cycles; minimum issue interval 3 cycles.
REQ-021 rsp_ready on the non-granted bit SHALL be ignored; rsp_valid SHALL be one-hot or zero.
REQ-022 ops_done SHALL increment by 1 on each RESP handshake and wrap from all-ones to 0.
REQ-023 A new request SHALL NOT be accepted in the cycle the RESP handshake completes; acceptance resumes in IDLE the next cycle.
REQ-024 Operand changes on the req buses after acceptance SHALL NOT affect the in-flight result.

Reset
REQ-025 While rst_n=0 the block SHALL force state IDLE, req_ready=0, rsp_valid=0, rsp_data=0, rsp_zero=0, busy=0, ops_done=0.
REQ-026 Reset SHALL set the round-robin history so requester 0 wins the first contended grant.
REQ-027 Reset asserted mid-operation SHALL discard the in-flight operation without a response or count increment.

Configuration
REQ-028 With macro ALU_ARB_FIXED_PRIO_EN defined, arbitration SHALL be fixed priority with requester 0 always winning contention; without it, round-robin per REQ-016.

Verification
REQ-029 Req0 only, op1=8'hF0, op2=8'h3C, op=00 -> req_ready=01, two cycles later rsp_valid=01, rsp_data=8'h30, rsp_zero=0.
REQ-030 Both valid continuously, rsp_ready=11 -> grants alternate 0,1,0,1; ops_done=4 after four handshakes (fixed 0,0,0,0 with ALU_ARB_FIXED_PRIO_EN).
REQ-031 Req1 op=10, op1=op2=8'hA5 -> rsp_data=8'h00, rsp_zero=1; op=11, op1=8'hFF -> rsp_data=8'h00, rsp_zero=1.
REQ-032 rsp_ready held 0 for 5 cycles in RESP -> rsp_valid/rsp_data stable, req_ready=00, busy=1 throughout.
REQ-033 rst_n pulsed low in EXEC -> all outputs 0 asynchronously, no response, ops_done=0, next contended grant to requester 0.
REQ-034 ops_done preloaded to all-ones via 2^CNT_W-1 handshakes (CNT_W=4 build) -> next handshake wraps it to 0.
